// File: rtl/cp0_regfile_v2_if.sv
`default_nettype none
// ============================================================================
// Module      : cp0_regfile_v2_if
// Description : MTC0/MFC0, commit-stage event and status bundle for the
//               second-generation CP0 register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface cp0_regfile_v2_if #(
  parameter int HW_INT_NUM = 6
);
  logic                  we_i;
  logic [4:0]            waddr_i;
  logic [4:0]            raddr_i;
  logic [31:0]           data_i;
  logic [31:0]           data_o;
  logic [HW_INT_NUM-1:0] int_i;
  logic                  exc_valid_i;
  logic [4:0]            exc_code_i;
  logic                  eret_i;
  logic [31:0]           pc_i;
  logic                  is_in_delayslot_i;
  logic                  bad_addr_valid_i;
  logic [31:0]           bad_addr_i;
  logic [31:0]           status_o;
  logic [31:0]           cause_o;
  logic [31:0]           epc_o;
  logic [31:0]           count_o;
  logic [31:0]           compare_o;
  logic [31:0]           badvaddr_o;
  logic                  timer_int_o;
  logic                  int_pending_o;

  modport master (
    output we_i, waddr_i, raddr_i, data_i, int_i, exc_valid_i, exc_code_i,
           eret_i, pc_i, is_in_delayslot_i, bad_addr_valid_i, bad_addr_i,
    input  data_o, status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o,
           timer_int_o, int_pending_o
  );

  modport slave (
    input  we_i, waddr_i, raddr_i, data_i, int_i, exc_valid_i, exc_code_i,
           eret_i, pc_i, is_in_delayslot_i, bad_addr_valid_i, bad_addr_i,
    output data_o, status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o,
           timer_int_o, int_pending_o
  );
endinterface
`default_nettype wire

// File: rtl/cp0_regfile_v2.sv
`default_nettype none
// ============================================================================
// Module      : cp0_regfile_v2
// Description : MIPS CP0 register file (BadVAddr, Count, Compare, Status,
//               Cause, EPC, PRId, Config) with precise exception / ERET
//               commit and a masked interrupt-pending request.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_regfile_v2 #(
  parameter int          HW_INT_NUM   = 6,
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] RESET_STATUS = 32'h1000_0000,
  parameter logic [31:0] PRID_VALUE   = 32'h004C_0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000
) (
  input  wire logic       clk,
  input  wire logic       rst,
  cp0_regfile_v2_if.slave bus
);

  localparam int                c_pw           = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [c_pw-1:0]   c_presc_max    = c_pw'(COUNT_DIV - 1);
  localparam logic [31:0]       c_status_wmask = 32'h0000_FF03;

  logic [31:0]     r_count;
  logic [c_pw-1:0] r_presc;
  logic [31:0]     r_compare;
  logic            r_timer;
  logic [31:0]     r_status;
  logic [31:0]     r_epc;
  logic [31:0]     r_badvaddr;
  logic            r_bd;
  logic [4:0]      r_exccode;
  logic [1:0]      r_sw_ip;
  logic [5:0]      r_hw_ip;

  logic [5:0]      w_int_ext;
  logic [31:0]     w_cause;
  logic            w_wr_count;
  logic            w_wr_compare;
  logic            w_wr_status;
  logic            w_wr_cause;
  logic            w_wr_epc;
  logic            w_exl;

  assign w_wr_count   = bus.we_i && (bus.waddr_i == 5'd9);
  assign w_wr_compare = bus.we_i && (bus.waddr_i == 5'd11);
  assign w_wr_status  = bus.we_i && (bus.waddr_i == 5'd12);
  assign w_wr_cause   = bus.we_i && (bus.waddr_i == 5'd13);
  assign w_wr_epc     = bus.we_i && (bus.waddr_i == 5'd14);
  assign w_exl        = r_status[1];

  // Unused hardware lines are tied low so they read back as zero in Cause.
  generate
    if (HW_INT_NUM >= 6) begin : g_int_full
      assign w_int_ext = bus.int_i[5:0];
    end else begin : g_int_pad
      assign w_int_ext = {{(6 - HW_INT_NUM){1'b0}}, bus.int_i};
    end
  endgenerate

  // Prescaler and Count; an MTC0 to Count overrides the increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= 32'd0;
      r_presc <= '0;
    end else if (w_wr_count) begin
      r_count <= bus.data_i;
      r_presc <= '0;
    end else if (r_presc == c_presc_max) begin
      r_count <= r_count + 32'd1;
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + c_pw'(1);
    end
  end

  // Compare and sticky timer flag; writing Compare clears the flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_compare <= 32'd0;
      r_timer   <= 1'b0;
    end else if (w_wr_compare) begin
      r_compare <= bus.data_i;
      r_timer   <= 1'b0;
    end else if ((r_compare != 32'd0) && (r_count == r_compare)) begin
      r_timer   <= 1'b1;
    end
  end

  // Status: masked MTC0 write, then EXL from exception/ERET takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status <= RESET_STATUS;
    end else begin
      if (w_wr_status)
        r_status <= (bus.data_i & c_status_wmask) | (RESET_STATUS & ~c_status_wmask);
      if (bus.exc_valid_i)
        r_status[1] <= 1'b1;
      else if (bus.eret_i)
        r_status[1] <= 1'b0;
    end
  end

  // Cause fields: sampled hardware IP, software IP, BD and ExcCode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hw_ip   <= 6'd0;
      r_sw_ip   <= 2'd0;
      r_bd      <= 1'b0;
      r_exccode <= 5'd0;
    end else begin
      r_hw_ip <= w_int_ext;
      if (w_wr_cause)
        r_sw_ip <= bus.data_i[9:8];
      if (bus.exc_valid_i) begin
        r_exccode <= bus.exc_code_i;
        if (!w_exl)
          r_bd <= bus.is_in_delayslot_i;
      end
    end
  end

  // EPC is protected while EXL is set; commit events block an MTC0 to EPC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_epc      <= 32'd0;
      r_badvaddr <= 32'd0;
    end else begin
      if (bus.exc_valid_i) begin
        if (!w_exl)
          r_epc <= bus.is_in_delayslot_i ? (bus.pc_i - 32'd4) : bus.pc_i;
        if (bus.bad_addr_valid_i)
          r_badvaddr <= bus.bad_addr_i;
      end else if (w_wr_epc && !bus.eret_i) begin
        r_epc <= bus.data_i;
      end
    end
  end

  assign w_cause = {r_bd, r_timer, 14'd0, r_hw_ip[5] | r_timer, r_hw_ip[4:0],
                    r_sw_ip, 1'b0, r_exccode, 2'b00};

  // MFC0 read mux, straight from register state (no write bypass).
  always_comb begin
    bus.data_o = 32'd0;
    case (bus.raddr_i)
      5'd8:    bus.data_o = r_badvaddr;
      5'd9:    bus.data_o = r_count;
      5'd11:   bus.data_o = r_compare;
      5'd12:   bus.data_o = r_status;
      5'd13:   bus.data_o = w_cause;
      5'd14:   bus.data_o = r_epc;
      5'd15:   bus.data_o = PRID_VALUE;
      5'd16:   bus.data_o = CONFIG_VALUE;
      default: bus.data_o = 32'd0;
    endcase
  end

  assign bus.status_o      = r_status;
  assign bus.cause_o       = w_cause;
  assign bus.epc_o         = r_epc;
  assign bus.count_o       = r_count;
  assign bus.compare_o     = r_compare;
  assign bus.badvaddr_o    = r_badvaddr;
  assign bus.timer_int_o   = r_timer;
  assign bus.int_pending_o = r_status[0] & ~w_exl & (|(w_cause[15:8] & r_status[15:8]));

endmodule
`default_nettype wire

// File: tb/tb_cp0_regfile_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_regfile_v2
// Description : Self-checking bench for cp0_regfile_v2 with a field-level
//               reference model and directed plus randomized scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_regfile_v2;

  localparam int          c_div   = 2;
  localparam logic [31:0] c_rst_s = 32'h1000_0000;
  localparam logic [31:0] c_prid  = 32'h004C_0102;
  localparam logic [31:0] c_cfg   = 32'h0000_8000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cp0_regfile_v2_if #(.HW_INT_NUM(6)) bus ();

  cp0_regfile_v2 #(
    .HW_INT_NUM(6), .COUNT_DIV(c_div), .RESET_STATUS(c_rst_s),
    .PRID_VALUE(c_prid), .CONFIG_VALUE(c_cfg)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [31:0] count, compare, status, epc, badv;
    int          phase;
    logic        timer, bd;
    logic [4:0]  exc;
    logic [1:0]  sw;
    logic [5:0]  hw;
  } model_t;

  model_t m;

  function automatic model_t m_reset_state();
    model_t s;
    s.count = 0; s.compare = 0; s.status = c_rst_s; s.epc = 0; s.badv = 0;
    s.phase = 0; s.timer = 0; s.bd = 0; s.exc = 0; s.sw = 0; s.hw = 0;
    return s;
  endfunction

  function automatic logic [31:0] m_cause(model_t s);
    logic [31:0] c;
    c = 32'(s.bd) << 31;
    c = c | (32'(s.timer) << 30);
    c = c | (32'(s.hw[5] | s.timer) << 15);
    c = c | (32'(s.hw[4:0]) << 10);
    c = c | (32'(s.sw) << 8);
    c = c | (32'(s.exc) << 2);
    return c;
  endfunction

  function automatic logic m_pend(model_t s);
    logic [7:0] ip, im;
    ip = 8'(m_cause(s) >> 8);
    im = 8'(s.status >> 8);
    return s.status[0] && !s.status[1] && ((ip & im) != 8'd0);
  endfunction

  function automatic logic [31:0] m_read(model_t s, logic [4:0] a);
    case (a)
      5'd8:    return s.badv;
      5'd9:    return s.count;
      5'd11:   return s.compare;
      5'd12:   return s.status;
      5'd13:   return m_cause(s);
      5'd14:   return s.epc;
      5'd15:   return c_prid;
      5'd16:   return c_cfg;
      default: return 32'd0;
    endcase
  endfunction

  // Next architectural state from the current inputs, rule by rule.
  function automatic model_t m_next(model_t s);
    model_t n;
    logic wr;
    logic [4:0] a;
    logic [31:0] d;
    n = s; wr = bus.we_i; a = bus.waddr_i; d = bus.data_i;
    if (!rst) return m_reset_state();
    if (wr && a == 5'd9) begin
      n.count = d; n.phase = 0;
    end else begin
      n.phase = s.phase + 1;
      if (n.phase == c_div) begin n.count = s.count + 1; n.phase = 0; end
    end
    if (wr && a == 5'd11) begin n.compare = d; n.timer = 1'b0; end
    else if (s.compare != 0 && s.count == s.compare) n.timer = 1'b1;
    if (wr && a == 5'd12) n.status = (d & 32'h0000_FF03) | (c_rst_s & ~32'h0000_FF03);
    if (wr && a == 5'd13) n.sw = d[9:8];
    n.hw = bus.int_i;
    if (wr && a == 5'd14 && !bus.exc_valid_i && !bus.eret_i) n.epc = d;
    if (bus.exc_valid_i) begin
      if (!s.status[1]) begin
        n.epc = bus.is_in_delayslot_i ? bus.pc_i - 4 : bus.pc_i;
        n.bd  = bus.is_in_delayslot_i;
      end
      n.status[1] = 1'b1;
      n.exc = bus.exc_code_i;
      if (bus.bad_addr_valid_i) n.badv = bus.bad_addr_i;
    end else if (bus.eret_i) begin
      n.status[1] = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [225:0] exp_vec();
    return {m_read(m, bus.raddr_i), m.status, m_cause(m), m.epc, m.count,
            m.compare, m.badv, m.timer, m_pend(m)};
  endfunction

  function automatic logic [225:0] obs_vec();
    return {bus.data_o, bus.status_o, bus.cause_o, bus.epc_o, bus.count_o,
            bus.compare_o, bus.badvaddr_o, bus.timer_int_o, bus.int_pending_o};
  endfunction

  task automatic tick();
    model_t n;
    n = m_next(m);
    @(posedge clk);
    #1;
    m = n;
  endtask

  task automatic idle();
    bus.we_i = 0; bus.waddr_i = 0; bus.data_i = 0; bus.exc_valid_i = 0;
    bus.exc_code_i = 0; bus.eret_i = 0; bus.pc_i = 0; bus.is_in_delayslot_i = 0;
    bus.bad_addr_valid_i = 0; bus.bad_addr_i = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we_i = 1; bus.waddr_i = a; bus.data_i = d;
    tick();
    bus.we_i = 0;
  endtask

  task automatic take_exc(input logic [31:0] pc, input logic ds, input logic [4:0] code,
                          input logic bv, input logic [31:0] bad);
    bus.exc_valid_i = 1; bus.pc_i = pc; bus.is_in_delayslot_i = ds;
    bus.exc_code_i = code; bus.bad_addr_valid_i = bv; bus.bad_addr_i = bad;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle(); bus.int_i = 0; bus.raddr_i = 5'd12; rst = 0;
    repeat (2) @(posedge clk);
    #1;
    m = m_reset_state();
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reset_state: got %h want %h", obs_vec(), exp_vec());
    end
    n_cmp++;
    if (bus.data_o !== 32'h1000_0000) begin
      n_err++; $display("FAIL reset_status_read: got %h want %h", bus.data_o, 32'h1000_0000);
    end
    rst = 1;
    bus.raddr_i = 5'd9;
    tick();
    n_cmp++;
    if (bus.data_o !== 32'd0) begin
      n_err++; $display("FAIL count_first: got %h want %h", bus.data_o, 32'd0);
    end
    tick();
    n_cmp++;
    if (bus.data_o !== 32'd1) begin
      n_err++; $display("FAIL count_second: got %h want %h", bus.data_o, 32'd1);
    end
    bus.raddr_i = 5'd15;
    #1;
    n_cmp++;
    if (bus.data_o !== 32'h004C_0102) begin
      n_err++; $display("FAIL prid_read: got %h want %h", bus.data_o, 32'h004C_0102);
    end
  endtask

  task automatic test_timer();
    bus.raddr_i = 5'd13;
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    for (int i = 0; i < 60 && !bus.timer_int_o; i++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL timer_run: got %h want %h", obs_vec(), exp_vec());
      end
    end
    n_cmp++;
    if ({bus.timer_int_o, bus.cause_o[30], bus.cause_o[15]} !== 3'b111) begin
      n_err++; $display("FAIL timer_rise: got %b want %b",
                        {bus.timer_int_o, bus.cause_o[30], bus.cause_o[15]}, 3'b111);
    end
    mtc0(5'd11, 32'd50);
    mtc0(5'd9, 32'd46);
    for (int i = 0; i < 20 && m.count != 32'd50; i++) tick();
    mtc0(5'd11, 32'd50);
    n_cmp++;
    if (bus.timer_int_o !== 1'b0) begin
      n_err++; $display("FAIL timer_clear_wins: got %b want %b", bus.timer_int_o, 1'b0);
    end
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL timer_after_clear: got %h want %h", obs_vec(), exp_vec());
    end
    mtc0(5'd11, 32'd0);
  endtask

  task automatic test_status();
    bus.raddr_i = 5'd12;
    mtc0(5'd12, 32'hFFFF_FFFF);
    n_cmp++;
    if (bus.data_o !== 32'h1000_FF03) begin
      n_err++; $display("FAIL status_mask: got %h want %h", bus.data_o, 32'h1000_FF03);
    end
    mtc0(5'd12, 32'h0000_FF01);
    mtc0(5'd13, 32'h0000_0100);
    n_cmp++;
    if (bus.int_pending_o !== 1'b1) begin
      n_err++; $display("FAIL sw_int_pending: got %b want %b", bus.int_pending_o, 1'b1);
    end
    take_exc(32'h8000_0000, 1'b0, 5'd0, 1'b0, 32'd0);
    n_cmp++;
    if (bus.int_pending_o !== 1'b0) begin
      n_err++; $display("FAIL exl_masks_int: got %b want %b", bus.int_pending_o, 1'b0);
    end
    bus.eret_i = 1; tick(); idle();
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL eret_reopens: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_exception();
    bus.raddr_i = 5'd14;
    take_exc(32'hBFC0_0100, 1'b1, 5'd4, 1'b1, 32'h0000_0003);
    n_cmp++;
    if ({bus.epc_o, bus.cause_o[31], bus.cause_o[6:2], bus.badvaddr_o, bus.status_o[1]} !==
        {32'hBFC0_00FC, 1'b1, 5'd4, 32'h0000_0003, 1'b1}) begin
      n_err++; $display("FAIL exc_first: got epc %h cause %h badv %h status %h",
                        bus.epc_o, bus.cause_o, bus.badvaddr_o, bus.status_o);
    end
    take_exc(32'h8000_0180, 1'b0, 5'd5, 1'b0, 32'hDEAD_BEEF);
    n_cmp++;
    if ({bus.epc_o, bus.cause_o[31], bus.cause_o[6:2], bus.badvaddr_o} !==
        {32'hBFC0_00FC, 1'b1, 5'd5, 32'h0000_0003}) begin
      n_err++; $display("FAIL exc_nested: got epc %h cause %h badv %h",
                        bus.epc_o, bus.cause_o, bus.badvaddr_o);
    end
  endtask

  task automatic test_simultaneous();
    bus.eret_i = 1;
    take_exc(32'h8000_0200, 1'b0, 5'd8, 1'b0, 32'd0);
    n_cmp++;
    if (bus.status_o[1] !== 1'b1) begin
      n_err++; $display("FAIL exc_beats_eret: got %b want %b", bus.status_o[1], 1'b1);
    end
    bus.eret_i = 1; tick(); idle();
    n_cmp++;
    if (bus.status_o[1] !== 1'b0) begin
      n_err++; $display("FAIL eret_clears_exl: got %b want %b", bus.status_o[1], 1'b0);
    end
    bus.we_i = 1; bus.waddr_i = 5'd14; bus.data_i = 32'h0000_1234;
    take_exc(32'h8000_1000, 1'b0, 5'd10, 1'b0, 32'd0);
    n_cmp++;
    if (bus.epc_o !== 32'h8000_1000) begin
      n_err++; $display("FAIL exc_beats_mtc0_epc: got %h want %h", bus.epc_o, 32'h8000_1000);
    end
    bus.eret_i = 1; tick(); idle();
  endtask

  task automatic test_random();
    logic [4:0] addrs [9] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
    for (int i = 0; i < 400; i++) begin
      bus.we_i              = ($urandom_range(0, 1) == 1);
      bus.waddr_i           = addrs[$urandom_range(0, 8)];
      bus.data_i            = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      bus.raddr_i           = addrs[$urandom_range(0, 8)];
      bus.exc_valid_i       = ($urandom_range(0, 7) == 0);
      bus.eret_i            = ($urandom_range(0, 5) == 0);
      bus.exc_code_i        = 5'($urandom);
      bus.pc_i              = $urandom & 32'hFFFF_FFFC;
      bus.is_in_delayslot_i = 1'($urandom);
      bus.bad_addr_valid_i  = 1'($urandom);
      bus.bad_addr_i        = $urandom;
      if ($urandom_range(0, 3) == 0) bus.int_i = 6'($urandom);
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random_%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    idle();
    bus.int_i = 0;
  endtask

  task automatic test_async_reset();
    bus.raddr_i = 5'd9;
    mtc0(5'd11, 32'd37);
    mtc0(5'd9, 32'd37);
    tick();
    n_cmp++;
    if (bus.timer_int_o !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_timer: got %b want %b", bus.timer_int_o, 1'b1);
    end
    #2;
    rst = 0;
    #1;
    m = m_reset_state();
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL async_reset: got %h want %h", obs_vec(), exp_vec());
    end
    tick();
    rst = 1;
    tick();
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_err++; $display("FAIL post_reset: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_status();
    test_exception();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
